// File: rtl/frm_irq_pkg.sv
// Shared types for the frame-completion monitor: FSM states and error-bit indices.
package frm_irq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } frm_state_e;

    localparam int ERR_SHORT = 0;
    localparam int ERR_LONG  = 1;
    localparam int ERR_HSIZE = 2;

endpackage

// File: rtl/frm_line_cnt.sv
// Pixel/line counters with sizes latched at SOF; emits last-line and bad-width strobes.
module frm_line_cnt #(
    parameter int VSIZE_W = 12,
    parameter int HSIZE_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sof,
    input  logic               eol,
    input  logic               cnt_en,
    input  logic [VSIZE_W-1:0] img_vsize,
    input  logic [HSIZE_W-1:0] img_hsize,
    output logic [VSIZE_W-1:0] line_cnt_o,
    output logic               last_line_o,
    output logic               hsize_bad_o
);

    logic [VSIZE_W-1:0] vsize_q, line_q, line_d, line_base, line_inc, vsize_eff;
    logic [HSIZE_W-1:0] hsize_q, pix_q, pix_d, pix_base, pix_inc, hsize_eff;
    logic               eol_cnt;

    // A SOF restart is applied before the same beat's pixel/EOL is counted.
    always_comb begin
        vsize_eff = sof ? img_vsize : vsize_q;
        hsize_eff = sof ? img_hsize : hsize_q;
        line_base = sof ? '0 : line_q;
        pix_base  = sof ? '0 : pix_q;
        line_inc  = (&line_base) ? line_base : line_base + 1'b1;
        pix_inc   = (&pix_base) ? pix_base : pix_base + 1'b1;
        line_d    = line_base;
        pix_d     = pix_base;
        if (cnt_en) begin
            pix_d = eol ? '0 : pix_inc;
            if (eol) line_d = line_inc;
        end
    end

    assign eol_cnt     = cnt_en & eol;
    assign last_line_o = eol_cnt && (line_inc == vsize_eff);
    assign hsize_bad_o = eol_cnt && (hsize_eff != '0) && (pix_inc != hsize_eff);
    assign line_cnt_o  = line_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vsize_q <= '0;
            hsize_q <= '0;
            line_q  <= '0;
            pix_q   <= '0;
        end else begin
            line_q <= line_d;
            pix_q  <= pix_d;
            if (sof) begin
                vsize_q <= img_vsize;
                hsize_q <= img_hsize;
            end
        end
    end

endmodule

// File: rtl/frm_done_irq.sv
// AXI4-Stream frame-completion monitor: FSM, sticky/pulse IRQ, error flags.
// Define FRM_ERR_CNT_EN to build the saturating error counter behind err_cnt.
module frm_done_irq
    import frm_irq_pkg::*;
#(
    parameter int VSIZE_W   = 12,
    parameter int HSIZE_W   = 12,
    parameter int FCNT_W    = 16,
    parameter int IRQ_PULSE = 0
) (
    input  logic               s_axis_aclk,
    input  logic               s_axis_areset,
    input  logic               s_axis_tvalid,
    input  logic               s_axis_tready,
    input  logic               s_axis_tlast,
    input  logic               s_axis_tuser,
    input  logic [VSIZE_W-1:0] img_vsize,
    input  logic [HSIZE_W-1:0] img_hsize,
    input  logic               irq_en,
    input  logic               irq_clr,
    output logic               frm_cmp_irq,
    output logic [FCNT_W-1:0]  frm_cnt,
    output logic [VSIZE_W-1:0] line_cnt,
    output logic [2:0]         err_flags,
    output logic [7:0]         err_cnt
);

    logic       beat, sof, eol, cnt_en, last_line, hsize_bad;
    logic       irq_q;
    logic [FCNT_W-1:0] frm_cnt_q;
    logic [2:0] err_q, err_d, err_set;
    frm_state_e state_q;

    assign beat   = s_axis_tvalid & s_axis_tready;
    assign sof    = beat & s_axis_tuser;
    assign eol    = beat & s_axis_tlast;
    assign cnt_en = beat & (sof ? (img_vsize != '0) : (state_q == ACTIVE));

    frm_line_cnt #(
        .VSIZE_W (VSIZE_W),
        .HSIZE_W (HSIZE_W)
    ) u_line_cnt (
        .clk         (s_axis_aclk),
        .rst         (s_axis_areset),
        .sof         (sof),
        .eol         (eol),
        .cnt_en      (cnt_en),
        .img_vsize   (img_vsize),
        .img_hsize   (img_hsize),
        .line_cnt_o  (line_cnt),
        .last_line_o (last_line),
        .hsize_bad_o (hsize_bad)
    );

    // New error events win over irq_clr in the same cycle.
    always_comb begin
        err_set            = '0;
        err_set[ERR_SHORT] = sof && (state_q == ACTIVE);
        err_set[ERR_LONG]  = eol && !sof && (state_q == DONE);
        err_set[ERR_HSIZE] = hsize_bad;
        err_d              = (irq_clr ? 3'b000 : err_q) | err_set;
    end

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            state_q   <= IDLE;
            irq_q     <= 1'b0;
            frm_cnt_q <= '0;
            err_q     <= '0;
        end else begin
            err_q <= err_d;
            if (last_line) frm_cnt_q <= frm_cnt_q + 1'b1;
            if (IRQ_PULSE != 0) irq_q <= last_line;
            else                irq_q <= last_line | (irq_q & ~irq_clr);
            case (state_q)
                IDLE: begin
                    if (sof && img_vsize != '0) state_q <= last_line ? DONE : ACTIVE;
                end
                ACTIVE, DONE: begin
                    if (sof)            state_q <= (img_vsize == '0) ? IDLE : (last_line ? DONE : ACTIVE);
                    else if (last_line) state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign frm_cmp_irq = irq_q & irq_en;
    assign frm_cnt     = frm_cnt_q;
    assign err_flags   = err_q;

`ifdef FRM_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset)
            err_cnt_q <= 8'd0;
        else if ((|(err_set & ~err_q)) && err_cnt_q != 8'hFF)
            err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_frm_done_irq.sv
// Directed bench for frm_done_irq: sticky-IRQ and pulse-IRQ instances share one stimulus.
module tb_frm_done_irq;

    localparam int VW = 12;
    localparam int HW = 12;
    localparam int FW = 16;

`ifdef FRM_ERR_CNT_EN
    localparam bit ECNT = 1'b1;
`else
    localparam bit ECNT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          tvalid, tready, tlast, tuser;
    logic [VW-1:0] vsize;
    logic [HW-1:0] hsize;
    logic          irq_en, irq_clr;

    logic          irq_l, irq_p;
    logic [FW-1:0] fcnt_l, fcnt_p;
    logic [VW-1:0] lcnt_l, lcnt_p;
    logic [2:0]    err_l, err_p;
    logic [7:0]    ecnt_l, ecnt_p;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    frm_done_irq #(.VSIZE_W(VW), .HSIZE_W(HW), .FCNT_W(FW), .IRQ_PULSE(0)) u_lvl (
        .s_axis_aclk(clk), .s_axis_areset(rst), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
        .s_axis_tlast(tlast), .s_axis_tuser(tuser), .img_vsize(vsize), .img_hsize(hsize),
        .irq_en(irq_en), .irq_clr(irq_clr), .frm_cmp_irq(irq_l), .frm_cnt(fcnt_l),
        .line_cnt(lcnt_l), .err_flags(err_l), .err_cnt(ecnt_l)
    );

    frm_done_irq #(.VSIZE_W(VW), .HSIZE_W(HW), .FCNT_W(FW), .IRQ_PULSE(1)) u_pls (
        .s_axis_aclk(clk), .s_axis_areset(rst), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
        .s_axis_tlast(tlast), .s_axis_tuser(tuser), .img_vsize(vsize), .img_hsize(hsize),
        .irq_en(irq_en), .irq_clr(irq_clr), .frm_cmp_irq(irq_p), .frm_cnt(fcnt_p),
        .line_cnt(lcnt_p), .err_flags(err_p), .err_cnt(ecnt_p)
    );

    function automatic logic [31:0] ecnt_exp(input int n);
        return ECNT ? 32'(n) : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with the given bus values; returns 1 time unit after the edge.
    task automatic cyc(input logic v, input logic r, input logic l, input logic u);
        tvalid = v; tready = r; tlast = l; tuser = u;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clr();
        irq_clr = 1'b1;
        idle(1);
        irq_clr = 1'b0;
    endtask

    // With stall set, even pixels and the tlast pixel are first offered with ready low.
    task automatic send_line(input int npix, input bit sof, input bit stall);
        logic l, u;
        for (int i = 0; i < npix; i++) begin
            l = (i == npix - 1);
            u = sof && (i == 0);
            if (stall && ((i % 2 == 0) || l)) cyc(1'b1, 1'b0, l, u);
            cyc(1'b1, 1'b1, l, u);
        end
    endtask

    task automatic send_frame(input int nl, input int np, input bit stall);
        for (int i = 0; i < nl; i++) send_line(np, i == 0, stall);
    endtask

    initial begin
        rst = 1'b1; tvalid = 0; tready = 0; tlast = 0; tuser = 0;
        vsize = 12'd4; hsize = 12'd8; irq_en = 1'b1; irq_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_irq", 32'(irq_l), 32'd0);
        chk("rst_frm_cnt", 32'(fcnt_l), 32'd0);
        chk("rst_line_cnt", 32'(lcnt_l), 32'd0);
        chk("rst_err", 32'(err_l), 32'd0);
        chk("rst_err_cnt", 32'(ecnt_l), 32'd0);

        // Clean frame, tready always high.
        for (int i = 0; i < 3; i++) send_line(8, i == 0, 1'b0);
        chk("f1_line3", 32'(lcnt_l), 32'd3);
        chk("f1_irq_early", 32'(irq_l), 32'd0);
        send_line(8, 1'b0, 1'b0);
        chk("f1_irq_lvl", 32'(irq_l), 32'd1);
        chk("f1_irq_pls", 32'(irq_p), 32'd1);
        chk("f1_frm_cnt", 32'(fcnt_l), 32'd1);
        chk("f1_line4", 32'(lcnt_l), 32'd4);
        idle(1);
        chk("f1_irq_lvl_hold", 32'(irq_l), 32'd1);
        chk("f1_irq_pls_drop", 32'(irq_p), 32'd0);
        clr();
        chk("f1_clr", 32'(irq_l), 32'd0);

        // Second clean frame with backpressure, tlast held across a stall.
        send_frame(4, 8, 1'b1);
        chk("f2_frm_cnt", 32'(fcnt_l), 32'd2);
        chk("f2_line4", 32'(lcnt_l), 32'd4);
        chk("f2_err", 32'(err_l), 32'd0);
        chk("f2_irq", 32'(irq_l), 32'd1);
        clr();

        // Short frame: SOF after 2 of 4 lines.
        send_line(8, 1'b1, 1'b0);
        send_line(8, 1'b0, 1'b0);
        chk("sh_line2", 32'(lcnt_l), 32'd2);
        chk("sh_err_pre", 32'(err_l), 32'd0);
        send_frame(4, 8, 1'b0);
        chk("sh_err", 32'(err_l), 32'b001);
        chk("sh_frm_cnt", 32'(fcnt_l), 32'd3);
        chk("sh_irq", 32'(irq_l), 32'd1);
        chk("sh_err_cnt", 32'(ecnt_l), ecnt_exp(1));
        clr();
        chk("sh_clr_irq", 32'(irq_l), 32'd0);
        chk("sh_clr_err", 32'(err_l), 32'd0);
        chk("sh_clr_err_cnt", 32'(ecnt_l), ecnt_exp(1));

        // Long frame: extra fifth line before the next SOF.
        send_frame(4, 8, 1'b0);
        chk("lg_frm_cnt", 32'(fcnt_l), 32'd4);
        send_line(8, 1'b0, 1'b0);
        chk("lg_err", 32'(err_l), 32'b010);
        chk("lg_line_sat", 32'(lcnt_l), 32'd4);
        chk("lg_err_cnt", 32'(ecnt_l), ecnt_exp(2));
        clr();
        chk("lg_clr_irq", 32'(irq_l), 32'd0);
        chk("lg_clr_err", 32'(err_l), 32'd0);
        chk("lg_clr_frm_cnt", 32'(fcnt_l), 32'd4);

        // Bad width on the last line, irq_clr held through the completing beat.
        for (int i = 0; i < 3; i++) send_line(8, i == 0, 1'b0);
        irq_clr = 1'b1;
        send_line(7, 1'b0, 1'b0);
        irq_clr = 1'b0;
        chk("hs_irq_setwins", 32'(irq_l), 32'd1);
        chk("hs_irq_pls", 32'(irq_p), 32'd1);
        chk("hs_err_setwins", 32'(err_l), 32'b100);
        chk("hs_frm_cnt", 32'(fcnt_l), 32'd5);
        chk("hs_err_cnt", 32'(ecnt_l), ecnt_exp(3));

        // Masked IRQ: pulse is lost, sticky shows once enabled.
        clr();
        irq_en = 1'b0;
        send_frame(4, 8, 1'b0);
        chk("msk_irq_lvl", 32'(irq_l), 32'd0);
        chk("msk_irq_pls", 32'(irq_p), 32'd0);
        chk("msk_frm_cnt", 32'(fcnt_l), 32'd6);
        irq_en = 1'b1;
        idle(1);
        chk("msk_irq_lvl_pend", 32'(irq_l), 32'd1);
        chk("msk_irq_pls_none", 32'(irq_p), 32'd0);

        // One-line frame with SOF and EOL on the same beat.
        clr();
        vsize = 12'd1; hsize = 12'd0;
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("v1_frm_cnt", 32'(fcnt_l), 32'd7);
        chk("v1_line", 32'(lcnt_l), 32'd1);
        chk("v1_irq_lvl", 32'(irq_l), 32'd1);
        chk("v1_irq_pls", 32'(irq_p), 32'd1);
        chk("v1_err", 32'(err_l), 32'd0);
        chk("v1_pls_mirror", {1'b0, fcnt_p, lcnt_p, err_p}, {1'b0, 16'd7, 12'd1, 3'd0});
        chk("v1_pls_err_cnt", 32'(ecnt_p), ecnt_exp(3));

        // vsize=0 at SOF parks the block; later EOLs raise nothing.
        vsize = 12'd0; hsize = 12'd8;
        send_line(8, 1'b1, 1'b0);
        send_line(8, 1'b0, 1'b0);
        chk("v0_frm_cnt", 32'(fcnt_l), 32'd7);
        chk("v0_err", 32'(err_l), 32'd0);
        chk("v0_irq_sticky", 32'(irq_l), 32'd1);

        // Reset mid-frame discards everything.
        vsize = 12'd4;
        send_line(8, 1'b1, 1'b0);
        chk("mr_line1", 32'(lcnt_l), 32'd1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("mr_line", 32'(lcnt_l), 32'd0);
        chk("mr_frm_cnt", 32'(fcnt_l), 32'd0);
        chk("mr_irq", 32'(irq_l), 32'd0);
        chk("mr_err", 32'(err_l), 32'd0);
        chk("mr_err_cnt", 32'(ecnt_l), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
